// File: rtl/scratchpad_pkg.sv
// Shared types and default widths for the scratchpad arbiter slice.
package scratchpad_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_HOST  = 2'd1,
        OWN_ARRAY = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        S_RR    = 2'd0,
        S_LOCK  = 2'd1,
        S_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/scratchpad_arbiter_starve_cnt.sv
// Saturating wait counter; hit flags the cycle the count lands on MAX.
module arb_starve_cnt #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt;

    // next count: clear wins, increment stops at MAX
    always_comb begin
        count_nxt = count_r;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && (count_r != MAX_C)) begin
            count_nxt = count_r + CW'(1);
        end else begin
            count_nxt = count_r;
        end
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt;
        end
    end

    assign hit = (count_nxt == MAX_C);

endmodule

// File: rtl/scratchpad_arbiter.sv
// Shares the single-port scratchpad between the host bridge and the array
// controller: round-robin, array burst lock, forced host slot on starvation.
module scratchpad_arbiter
    import scratchpad_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(10'h355),
    parameter int                STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_valid,
    output logic              h_ready,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              starved
);

    arb_state_e        state_r;
    arb_state_e        state_nxt;
    logic              last_array_r;
    logic              h_xfer_s;
    logic              a_xfer_s;
    logic              grant_s;
    logic              cnt_inc_s;
    logic              cnt_clr_s;
    logic              cnt_hit_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              zero_hit_s;
    owner_e            rd_owner_r;
    logic              rd_zero_r;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] h_hold_r;
    logic [DATA_W-1:0] a_hold_r;

    assign h_xfer_s  = h_valid && h_ready;
    assign a_xfer_s  = a_valid && a_ready;
    assign grant_s   = h_xfer_s || a_xfer_s;
    assign cnt_inc_s = (state_r == S_LOCK) && h_valid;
    assign cnt_clr_s = !cnt_inc_s;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .hit   (cnt_hit_s)
    );

    // arbitration state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_RR;
        end else begin
            state_r <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_RR: begin
                if (a_xfer_s && a_lock) begin
                    state_nxt = S_LOCK;
                end else begin
                    state_nxt = S_RR;
                end
            end
            S_LOCK: begin
                if (!a_lock) begin
                    state_nxt = S_RR;
                end else if (cnt_hit_s) begin
                    state_nxt = S_FORCE;
                end else begin
                    state_nxt = S_LOCK;
                end
            end
            S_FORCE: begin
                if (a_lock) begin
                    state_nxt = S_LOCK;
                end else begin
                    state_nxt = S_RR;
                end
            end
            default: state_nxt = S_RR;
        endcase
    end

    // ready / status outputs from state and both valids
    always_comb begin
        h_ready = 1'b0;
        a_ready = 1'b0;
        starved = 1'b0;
        case (state_r)
            S_RR: begin
                h_ready = h_valid && (!a_valid || last_array_r);
                a_ready = a_valid && (!h_valid || !last_array_r);
            end
            S_LOCK: begin
                a_ready = a_valid;
            end
            S_FORCE: begin
                h_ready = 1'b1;
                starved = 1'b1;
            end
            default: begin
                h_ready = 1'b0;
                a_ready = 1'b0;
                starved = 1'b0;
            end
        endcase
    end

    // last-grant pointer; a lock release hands the next tie to the host
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_array_r <= 1'b1;
        end else if ((state_r == S_LOCK) && !a_lock) begin
            last_array_r <= 1'b1;
        end else if (h_xfer_s) begin
            last_array_r <= 1'b0;
        end else if (a_xfer_s) begin
            last_array_r <= 1'b1;
        end else begin
            last_array_r <= last_array_r;
        end
    end

    // select the granted request's fields
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (h_xfer_s) begin
            sel_we_s    = h_we;
            sel_addr_s  = h_addr;
            sel_wdata_s = h_wdata;
        end else if (a_xfer_s) begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = '0;
            sel_wdata_s = '0;
        end
    end

    assign zero_hit_s = grant_s && (sel_addr_s == ZERO_ADDR);
    assign m_en       = grant_s && !zero_hit_s;
    assign m_we       = m_en && sel_we_s;
    assign m_addr     = sel_addr_s;
    assign m_wdata    = sel_wdata_s;

    // read-return tag: who gets the data next cycle and whether it is the zero point
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_r <= OWN_NONE;
            rd_zero_r  <= 1'b0;
        end else if (h_xfer_s && !h_we) begin
            rd_owner_r <= OWN_HOST;
            rd_zero_r  <= zero_hit_s;
        end else if (a_xfer_s && !a_we) begin
            rd_owner_r <= OWN_ARRAY;
            rd_zero_r  <= zero_hit_s;
        end else begin
            rd_owner_r <= OWN_NONE;
            rd_zero_r  <= 1'b0;
        end
    end

    assign rd_data_s = rd_zero_r ? '0 : m_rdata;
    assign h_rvalid  = (rd_owner_r == OWN_HOST);
    assign a_rvalid  = (rd_owner_r == OWN_ARRAY);
    assign h_rdata   = h_rvalid ? rd_data_s : h_hold_r;
    assign a_rdata   = a_rvalid ? rd_data_s : a_hold_r;

    // hold the last returned word so rdata stays put between responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_hold_r <= '0;
            a_hold_r <= '0;
        end else begin
            h_hold_r <= h_rdata;
            a_hold_r <= a_rdata;
        end
    end

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter with a behavioural single-port memory.
module tb_scratchpad_arbiter;

    logic        clk;
    logic        reset;
    logic        h_valid, h_ready, h_we, h_rvalid;
    logic [9:0]  h_addr;
    logic [15:0] h_wdata, h_rdata;
    logic        a_valid, a_ready, a_we, a_lock, a_rvalid;
    logic [9:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        m_en, m_we;
    logic [9:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic        starved;

    logic [15:0] mem [0:1023];
    int          total;
    int          bad;

    scratchpad_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .h_valid  (h_valid),
        .h_ready  (h_ready),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_lock   (a_lock),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .starved  (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port memory, one-cycle read latency
    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr] <= m_wdata;
        if (m_en && !m_we) m_rdata <= mem[m_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        h_valid = 1'b0; h_we = 1'b0; h_addr = 10'd0; h_wdata = 16'h0000;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 10'd0; a_wdata = 16'h0000; a_lock = 1'b0;
    endtask

    task automatic host(input logic we, input logic [9:0] addr, input logic [15:0] data);
        h_valid = 1'b1; h_we = we; h_addr = addr; h_wdata = data;
    endtask

    task automatic arr(input logic we, input logic [9:0] addr, input logic [15:0] data, input logic lock);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = data; a_lock = lock;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_h_ready"},  {31'd0, h_ready},  32'd0);
        check_eq({tag, "_a_ready"},  {31'd0, a_ready},  32'd0);
        check_eq({tag, "_h_rvalid"}, {31'd0, h_rvalid}, 32'd0);
        check_eq({tag, "_a_rvalid"}, {31'd0, a_rvalid}, 32'd0);
        check_eq({tag, "_h_rdata"},  {16'd0, h_rdata},  32'd0);
        check_eq({tag, "_a_rdata"},  {16'd0, a_rdata},  32'd0);
        check_eq({tag, "_m_en"},     {31'd0, m_en},     32'd0);
        check_eq({tag, "_m_we"},     {31'd0, m_we},     32'd0);
        check_eq({tag, "_m_addr"},   {22'd0, m_addr},   32'd0);
        check_eq({tag, "_m_wdata"},  {16'd0, m_wdata},  32'd0);
        check_eq({tag, "_starved"},  {31'd0, starved},  32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_quiet("rst");
        @(negedge clk);
        reset = 1'b0;

        // both valid from reset: host, array, host, array
        host(1'b1, 10'd20, 16'h00a0);
        arr(1'b1, 10'd21, 16'h00b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("alt_h_ready", {31'd0, h_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("alt_a_ready", {31'd0, a_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // host write then read back
        idle(); host(1'b1, 10'd4, 16'h1111);
        #1;
        check_eq("wr_h_ready", {31'd0, h_ready}, 32'd1);
        check_eq("wr_m_en",    {31'd0, m_en},    32'd1);
        check_eq("wr_m_we",    {31'd0, m_we},    32'd1);
        check_eq("wr_m_addr",  {22'd0, m_addr},  32'd4);
        check_eq("wr_m_wdata", {16'd0, m_wdata}, 32'h1111);
        @(negedge clk);
        host(1'b0, 10'd4, 16'h0000);
        #1;
        check_eq("rd_h_ready", {31'd0, h_ready}, 32'd1);
        check_eq("rd_m_en",    {31'd0, m_en},    32'd1);
        check_eq("rd_m_we",    {31'd0, m_we},    32'd0);
        check_eq("rd_h_rvalid_early", {31'd0, h_rvalid}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        check_eq("rd_h_rvalid", {31'd0, h_rvalid}, 32'd1);
        check_eq("rd_h_rdata",  {16'd0, h_rdata},  32'h1111);
        check_eq("rd_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("rd_h_rvalid_end", {31'd0, h_rvalid}, 32'd0);
        check_eq("rd_h_rdata_hold", {16'd0, h_rdata},  32'h1111);

        // zero-point address: read returns 0, write dropped
        @(negedge clk);
        host(1'b0, 10'h355, 16'h0000);
        #1;
        check_eq("zp_rd_h_ready", {31'd0, h_ready}, 32'd1);
        check_eq("zp_rd_m_en",    {31'd0, m_en},    32'd0);
        @(negedge clk);
        host(1'b1, 10'h355, 16'h5555);
        #1;
        check_eq("zp_h_rvalid",   {31'd0, h_rvalid}, 32'd1);
        check_eq("zp_h_rdata",    {16'd0, h_rdata},  32'd0);
        check_eq("zp_wr_h_ready", {31'd0, h_ready},  32'd1);
        check_eq("zp_wr_m_en",    {31'd0, m_en},     32'd0);
        check_eq("zp_wr_m_we",    {31'd0, m_we},     32'd0);
        @(negedge clk);
        idle();
        #1 check_eq("zp_wr_no_rvalid", {31'd0, h_rvalid}, 32'd0);

        // preload 8, 10, 4 at addresses 0..2 through the host
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host(1'b1, 10'(i), (i == 0) ? 16'd8 : ((i == 1) ? 16'd10 : 16'd4));
            #1 check_eq("pre_h_ready", {31'd0, h_ready}, 32'd1);
        end

        // array back-to-back reads
        @(negedge clk);
        idle(); arr(1'b0, 10'd0, 16'h0000, 1'b0);
        #1;
        check_eq("b2b_a_ready", {31'd0, a_ready}, 32'd1);
        check_eq("b2b_m_addr0", {22'd0, m_addr},  32'd0);
        @(negedge clk);
        arr(1'b0, 10'd1, 16'h0000, 1'b0);
        #1;
        check_eq("b2b_rvalid0", {31'd0, a_rvalid}, 32'd1);
        check_eq("b2b_rdata0",  {16'd0, a_rdata},  32'd8);
        @(negedge clk);
        arr(1'b0, 10'd2, 16'h0000, 1'b0);
        #1;
        check_eq("b2b_rvalid1", {31'd0, a_rvalid}, 32'd1);
        check_eq("b2b_rdata1",  {16'd0, a_rdata},  32'd10);
        @(negedge clk);
        idle();
        #1;
        check_eq("b2b_rvalid2", {31'd0, a_rvalid}, 32'd1);
        check_eq("b2b_rdata2",  {16'd0, a_rdata},  32'd4);
        check_eq("b2b_h_rvalid", {31'd0, h_rvalid}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("b2b_rvalid_end", {31'd0, a_rvalid}, 32'd0);
        check_eq("b2b_rdata_hold", {16'd0, a_rdata},  32'd4);

        // burst lock with a waiting host: forced slot after 8 lock cycles
        @(negedge clk);
        arr(1'b1, 10'd30, 16'h0003, 1'b1);
        #1 check_eq("lk_enter_a_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        host(1'b1, 10'd40, 16'hbeef);
        for (int k = 1; k <= 8; k++) begin
            #1;
            check_eq("lk_h_ready", {31'd0, h_ready}, 32'd0);
            check_eq("lk_a_ready", {31'd0, a_ready}, 32'd1);
            check_eq("lk_starved", {31'd0, starved}, 32'd0);
            @(negedge clk);
        end
        #1;
        check_eq("force_h_ready", {31'd0, h_ready}, 32'd1);
        check_eq("force_a_ready", {31'd0, a_ready}, 32'd0);
        check_eq("force_starved", {31'd0, starved}, 32'd1);
        check_eq("force_m_addr",  {22'd0, m_addr},  32'd40);
        check_eq("force_m_wdata", {16'd0, m_wdata}, 32'hbeef);
        @(negedge clk);
        h_valid = 1'b0;
        #1;
        check_eq("resume_a_ready", {31'd0, a_ready}, 32'd1);
        check_eq("resume_starved", {31'd0, starved}, 32'd0);
        @(negedge clk);
        a_valid = 1'b0; a_lock = 1'b0;
        host(1'b1, 10'd41, 16'h0041);
        #1;
        check_eq("rel_h_ready", {31'd0, h_ready}, 32'd0);
        check_eq("rel_a_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        arr(1'b1, 10'd42, 16'h0042, 1'b0);
        #1;
        check_eq("rel_tie_h_ready", {31'd0, h_ready}, 32'd1);
        check_eq("rel_tie_a_ready", {31'd0, a_ready}, 32'd0);

        // reset right after an accepted host read
        @(negedge clk);
        idle(); host(1'b0, 10'd4, 16'h0000);
        #1 check_eq("rr_h_ready", {31'd0, h_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle();
        reset = 1'b1;
        #1 check_quiet("rst_rd");
        @(negedge clk);
        #1 check_eq("rst_rd_no_rvalid", {31'd0, h_rvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        host(1'b1, 10'd50, 16'h0050);
        arr(1'b1, 10'd51, 16'h0051, 1'b0);
        #1;
        check_eq("post_rst_h_ready", {31'd0, h_ready}, 32'd1);
        check_eq("post_rst_a_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scratchpad_arbiter.md
Name: scratchpad_arbiter

Overview:
- Shares the single-port 16-bit scratchpad between two requesters: the host side (SPI bus bridge: data load, result readback) and the array controller (operand fetch, result writeback).
- Single-cycle-accept, 1-cycle-read-latency memory port.
- Arbitration is round-robin, with an array burst lock and starvation protection for the host.
- Reads of the zero-point address return 0 without touching memory.

Parameters:
ADDR_W, 10, scratchpad word-address width
DATA_W, 16, data word width
ZERO_ADDR, 10'h355, zero-point address; reads return 0, writes dropped
STARVE_MAX, 8, max consecutive lock-held cycles a pending host request may wait

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
h_valid  in  1  host request valid
h_ready  out  1  host request accepted this cycle
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_W  host read data
a_valid  in  1  array request valid
a_ready  out  1  array request accepted this cycle
a_we  in  1  array write/read
a_addr  in  ADDR_W  array address
a_wdata  in  DATA_W  array write data
a_lock  in  1  array requests burst ownership
a_rvalid  out  1  array read data valid
a_rdata  out  DATA_W  array read data
m_en  out  1  memory access enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid 1 cycle after m_en&&!m_we
starved  out  1  forced host slot taken this cycle (status)

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle. h_ready and a_ready are combinational from the state and both valids. They are never both 1.
- Request fields must stay stable while valid && !ready.
- Memory port: m_en/m_we/m_addr/m_wdata are combinational from the granted request.
  - m_en = 0 when there is no grant, or when the granted address == ZERO_ADDR.
  - An access to ZERO_ADDR is still accepted.
- Read return: an accepted read registers {owner, zero_hit}. Next cycle, the owner's rvalid = 1 and rdata = zero_hit ? 0 : m_rdata. The other rvalid stays 0.
- rdata holds its value when rvalid = 0. Writes produce no response.
- Back-to-back reads are supported, one per cycle.
- State machine (states S_RR, S_LOCK, S_FORCE):
  - S_RR:
    - Only one valid: grant it.
    - Both valid: grant the requester not granted last. The last-grant pointer updates only on accept.
    - Array accepted with a_lock = 1 -> S_LOCK.
  - S_LOCK:
    - The array has absolute priority and h_ready = 0.
    - The starve counter increments each cycle h_valid = 1; it clears when h_valid = 0.
    - a_lock = 0 -> S_RR (same cycle the array may still be granted if a_valid).
    - Counter reaches STARVE_MAX -> S_FORCE.
  - S_FORCE:
    - h_ready = 1, a_ready = 0, starved = 1.
    - Exactly one host transfer, then return to S_LOCK if a_lock = 1, else S_RR. The counter clears.
    - If h_valid drops while in S_FORCE, return without a transfer.
- Simultaneous: a lock release and a host request in the same S_LOCK cycle are arbitrated next cycle in S_RR, and the pointer favours the host.
- Reset (async): state S_RR, pointer = array-last (host wins first tie), counter 0.
  - All outputs 0, rdata regs 0.
  - A read in flight at reset produces no rvalid.
- Width: the counter is $clog2(STARVE_MAX+1) bits and saturates; it has no wrap.

Decomposition:
- Shared package scratchpad_pkg: owner_e {OWN_NONE, OWN_HOST, OWN_ARRAY}, arb_state_e {S_RR, S_LOCK, S_FORCE}, default ADDR_W/DATA_W constants.
- One sub-module: arb_starve_cnt (saturating counter with clear, increment, and hit flag at STARVE_MAX).

Test Plan:
- Host write 16'h1111 to addr 4, then read addr 4 -> h_ready same cycle; h_rvalid next cycle with h_rdata = 16'h1111; a_rvalid stays 0.
- Host and array both valid for 4 cycles with no lock, starting from reset -> grants alternate host, array, host, array.
- Host read of addr 10'h355 -> m_en = 0, h_rvalid = 1, h_rdata = 0. Write of 16'h5555 to 10'h355 is accepted and m_en stays 0.
- Array holds a_lock = 1 and a_valid = 1 continuously while host is valid -> host granted alone on cycle STARVE_MAX+1 with starved = 1, then array resumes; verify with STARVE_MAX = 8.
- Array reads addrs 0, 1, 2 back-to-back with mem = {8, 10, 4} -> a_rvalid for 3 consecutive cycles, data 8, 10, 4.
- Reset asserted the cycle after an accepted read -> no rvalid, all outputs 0; after release, host wins the first tie.
